// File: rtl/spi_cmd_ctrl.sv
// Command sequencer for the SPI slave byte stream: decodes command + burst data per
// chip-select frame, keeps a small register bank and supplies the next tx byte.
//
// state      | meaning
// ST_IDLE    | waiting for a rising edge of sel_active
// ST_CMD     | frame open, next rx byte is the command
// ST_WDATA   | write burst, each byte stored at addr_ptr
// ST_RDATA   | read burst, each byte advances tx_byte to reg[addr_ptr]
// ST_DISCARD | bad command, rest of frame ignored
module spi_cmd_ctrl #(
    parameter logic [7:0] ID_VALUE = 8'h1C,
    parameter int         GPIO_W   = 4
) (
    input  logic              ico_clk,
    input  logic              ico_rst_n,
    input  logic              sel_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              wr_strobe,
    output logic [2:0]        wr_addr,
    output logic              frame_done,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_DISCARD
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_sel_q;
    logic       r_armed;
    logic [2:0] r_addr_ptr;
    logic [7:0] r_regs [0:5];
    logic [7:0] w_rbank [0:7];

    logic       w_start, w_cmd_ok;
    logic       w_tx_load, w_ptr_load, w_do_write, w_err_inc, w_frame_done;
    logic [7:0] w_tx_val;
    logic [2:0] w_ptr_val;

    // r_armed blocks a frame start until sel_active has been seen low, so a frame
    // already in progress when reset is released is never picked up half-way.
    assign w_start  = sel_active & ~r_sel_q & r_armed;
    assign w_cmd_ok = (rx_byte[6:3] == 4'b0000);
    assign gpio_out = r_regs[0][GPIO_W-1:0];

    always_comb begin
        for (int i = 0; i < 6; i++) w_rbank[i] = r_regs[i];
        w_rbank[6] = ID_VALUE;
        w_rbank[7] = err_count;
    end

    always_ff @(posedge ico_clk or negedge ico_rst_n) begin
        if (!ico_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_load    = 1'b0;
        w_tx_val     = 8'h00;
        w_ptr_load   = 1'b0;
        w_ptr_val    = r_addr_ptr;
        w_do_write   = 1'b0;
        w_err_inc    = 1'b0;
        w_frame_done = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_start) begin
                w_state_nxt = ST_CMD;
                w_tx_load   = 1'b1;
            end
        end else if (!sel_active) begin
            // deassertion wins over a coincident rx_valid
            w_state_nxt  = ST_IDLE;
            w_frame_done = 1'b1;
        end else if (rx_valid) begin
            case (r_state)
                ST_CMD: begin
                    if (!w_cmd_ok) begin
                        w_state_nxt = ST_DISCARD;
                        w_err_inc   = 1'b1;
                    end else if (rx_byte[7]) begin
                        w_state_nxt = ST_WDATA;
                        w_ptr_load  = 1'b1;
                        w_ptr_val   = rx_byte[2:0];
                    end else begin
                        w_state_nxt = ST_RDATA;
                        w_tx_load   = 1'b1;
                        w_tx_val    = w_rbank[rx_byte[2:0]];
                        w_ptr_load  = 1'b1;
                        w_ptr_val   = rx_byte[2:0] + 3'd1;
                    end
                end
                ST_WDATA: begin
                    w_ptr_load = 1'b1;
                    w_ptr_val  = r_addr_ptr + 3'd1;
                    if (r_addr_ptr < 3'd6) w_do_write = 1'b1;
                    else                   w_err_inc  = 1'b1;
                end
                ST_RDATA: begin
                    w_tx_load  = 1'b1;
                    w_tx_val   = w_rbank[r_addr_ptr];
                    w_ptr_load = 1'b1;
                    w_ptr_val  = r_addr_ptr + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ico_clk or negedge ico_rst_n) begin
        if (!ico_rst_n) begin
            r_sel_q    <= 1'b0;
            r_armed    <= 1'b0;
            r_addr_ptr <= 3'd0;
            tx_byte    <= 8'h00;
            wr_strobe  <= 1'b0;
            wr_addr    <= 3'd0;
            frame_done <= 1'b0;
            err_count  <= 8'h00;
            for (int i = 0; i < 6; i++) r_regs[i] <= 8'h00;
        end else begin
            r_sel_q    <= sel_active;
            if (!sel_active) r_armed <= 1'b1;
            frame_done <= w_frame_done;
            wr_strobe  <= w_do_write;
            if (w_do_write) wr_addr <= r_addr_ptr;
            if (w_tx_load)  tx_byte <= w_tx_val;
            if (w_ptr_load) r_addr_ptr <= w_ptr_val;
            if (w_err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
            for (int i = 0; i < 6; i++)
                if (w_do_write && r_addr_ptr == 3'(i)) r_regs[i] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed frames plus random frames, checked against a
// frame-level model of the register bank, error counter and tx stream.
module tb_spi_cmd_ctrl;

    logic       ico_clk = 1'b0;
    logic       ico_rst_n = 1'b0;
    logic       sel_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic [3:0] gpio_out;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic       frame_done;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] mregs [0:7];
    logic [7:0] merr;
    logic [7:0] frm [$];

    spi_cmd_ctrl #(.ID_VALUE(8'h1C), .GPIO_W(4)) dut (
        .ico_clk(ico_clk), .ico_rst_n(ico_rst_n), .sel_active(sel_active),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_byte(tx_byte),
        .gpio_out(gpio_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .frame_done(frame_done), .err_count(err_count)
    );

    always #5 ico_clk = ~ico_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [2:0] a);
        if (a < 3'd6)  return mregs[a];
        if (a == 3'd6) return 8'h1C;
        return merr;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        merr = 8'h00;
    endtask

    // called at a negedge; returns at the next negedge with outputs settled
    task automatic pulse_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge ico_clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_frame();
        logic       ok, wr, es;
        logic [2:0] ptr, eaddr;
        logic [7:0] etx;
        @(negedge ico_clk);
        sel_active = 1'b1;
        @(negedge ico_clk);
        @(negedge ico_clk);
        ok  = (frm[0][6:3] == 4'b0000);
        wr  = frm[0][7];
        ptr = frm[0][2:0];
        for (int i = 0; i < frm.size(); i++) begin
            etx = 8'h00; es = 1'b0; eaddr = 3'd0;
            if (i == 0) begin
                if (!ok) merr = sat_inc(merr);
                else if (!wr) begin etx = mread(ptr); ptr = ptr + 3'd1; end
            end else if (ok) begin
                if (wr) begin
                    if (ptr < 3'd6) begin mregs[ptr] = frm[i]; es = 1'b1; eaddr = ptr; end
                    else merr = sat_inc(merr);
                    ptr = ptr + 3'd1;
                end else begin
                    etx = mread(ptr);
                    ptr = ptr + 3'd1;
                end
            end
            pulse_byte(frm[i]);
            chk("tx_byte", 32'(tx_byte), 32'(etx));
            chk("wr_strobe", 32'(wr_strobe), 32'(es));
            if (es) chk("wr_addr", 32'(wr_addr), 32'(eaddr));
            chk("err_count", 32'(err_count), 32'(merr));
            chk("gpio_out", 32'(gpio_out), 32'(mregs[0][3:0]));
            @(negedge ico_clk);
            chk("wr_strobe_1cyc", 32'(wr_strobe), 32'd0);
        end
        sel_active = 1'b0;
        @(negedge ico_clk);
        chk("frame_done", 32'(frame_done), 32'd1);
        @(negedge ico_clk);
        chk("frame_done_1cyc", 32'(frame_done), 32'd0);
    endtask

    initial begin
        logic [7:0] cmd;
        int         len;
        model_reset();
        #12;
        chk("rst_tx", 32'(tx_byte), 32'd0);
        chk("rst_gpio", 32'(gpio_out), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        @(negedge ico_clk);
        ico_rst_n = 1'b1;
        @(negedge ico_clk);

        // write burst
        frm = '{8'h80, 8'h05, 8'hA3};
        do_frame();
        chk("gpio_after_write", 32'(gpio_out), 32'h5);

        // preload reg5, then read burst wrapping through 6, 7, 0
        frm = '{8'h85, 8'h55};
        do_frame();
        frm = '{8'h05, 8'h00, 8'h00, 8'h00};
        do_frame();

        // bad command, then write to read-only reg6
        frm = '{8'h48, 8'hFF};
        do_frame();
        frm = '{8'h86, 8'h11};
        do_frame();
        chk("err_two", 32'(err_count), 32'd2);
        frm = '{8'h06};
        do_frame();
        chk("id_read", 32'(tx_byte), 32'h1C);

        // abort: sel_active falls with rx_valid of a data byte
        @(negedge ico_clk);
        sel_active = 1'b1;
        @(negedge ico_clk);
        @(negedge ico_clk);
        pulse_byte(8'h80);
        @(negedge ico_clk);
        rx_byte = 8'h77; rx_valid = 1'b1; sel_active = 1'b0;
        @(negedge ico_clk);
        rx_valid = 1'b0;
        chk("abort_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("abort_frame_done", 32'(frame_done), 32'd1);
        chk("abort_gpio", 32'(gpio_out), 32'h5);
        @(negedge ico_clk);
        chk("abort_frame_done_1cyc", 32'(frame_done), 32'd0);
        pulse_byte(8'h80);
        chk("idle_ignore_strobe", 32'(wr_strobe), 32'd0);
        frm = '{8'h00};
        do_frame();

        // reset mid-frame with sel_active held high
        @(negedge ico_clk);
        sel_active = 1'b1;
        @(negedge ico_clk);
        @(negedge ico_clk);
        pulse_byte(8'h80);
        @(negedge ico_clk);
        ico_rst_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_tx", 32'(tx_byte), 32'd0);
        chk("mrst_gpio", 32'(gpio_out), 32'd0);
        chk("mrst_err", 32'(err_count), 32'd0);
        chk("mrst_frame_done", 32'(frame_done), 32'd0);
        @(negedge ico_clk);
        ico_rst_n = 1'b1;
        @(negedge ico_clk);
        @(negedge ico_clk);
        pulse_byte(8'h80);
        chk("mrst_ign_tx", 32'(tx_byte), 32'd0);
        @(negedge ico_clk);
        pulse_byte(8'h55);
        chk("mrst_ign_strobe", 32'(wr_strobe), 32'd0);
        chk("mrst_ign_gpio", 32'(gpio_out), 32'd0);
        chk("mrst_ign_err", 32'(err_count), 32'd0);
        sel_active = 1'b0;
        @(negedge ico_clk);
        chk("mrst_no_frame_done", 32'(frame_done), 32'd0);
        frm = '{8'h80, 8'h0F};
        do_frame();
        chk("mrst_recover_gpio", 32'(gpio_out), 32'hF);

        // random frames
        for (int n = 0; n < 40; n++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 7) != 0) cmd[6:3] = 4'b0000;
            else if (cmd[6:3] == 4'b0000) cmd[3] = 1'b1;
            len = $urandom_range(1, 5);
            frm = '{cmd};
            for (int k = 1; k < len; k++) frm.push_back(8'($urandom));
            do_frame();
        end

        // saturation
        for (int n = 0; n < 300; n++) begin
            frm = '{8'h48};
            do_frame();
        end
        chk("sat_err", 32'(err_count), 32'hFF);
        frm = '{8'h07};
        do_frame();
        chk("sat_read7", 32'(tx_byte), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer for the icoboard SPI slave byte datapath. It consumes the received-byte stream from the byte-level SPI slave, decodes each chip-select frame as a command byte followed by burst data, and maintains a small register bank. It supplies the next byte to transmit back to the Raspberry Pi and drives the board GPIO outputs from register 0.

## Interface
Parameters:
- ID_VALUE, 8'h1C, constant returned by read-only register 6
- GPIO_W, 4, number of gpio_out bits driven from reg0[GPIO_W-1:0]; legal range 1..8

Ports:
- ico_clk  input  1  system clock; all logic on its rising edge
- ico_rst_n  input  1  asynchronous, active-low reset
- sel_active  input  1  synchronized chip-select, high while a frame is in progress
- rx_valid  input  1  one-cycle pulse: rx_byte holds a complete received byte
- rx_byte  input  8  received byte, MSB first on the wire
- tx_byte  output  8  byte the slave shifts out during the next byte slot
- gpio_out  output  GPIO_W  reg0[GPIO_W-1:0]
- wr_strobe  output  1  one-cycle pulse on every accepted register write
- wr_addr  output  3  address of the write flagged by wr_strobe
- frame_done  output  1  one-cycle pulse when sel_active falls in a non-IDLE state
- err_count  output  8  saturating protocol-error counter (also register 7)

## Operation
- Register map:
  - 0–5: read/write, reset 8'h00.
  - 6: read-only ID_VALUE.
  - 7: read-only err_count.
- Command byte:
  - bit7: 1 = write, 0 = read.
  - bits[6:3]: must be 0.
  - bits[2:0]: start address.
- State machine: IDLE, CMD, WDATA, RDATA, DISCARD.
  - IDLE -> CMD: rising edge of sel_active, detected against a registered copy. On entry, tx_byte <= 8'h00.
  - CMD, rx_valid with bits[6:3]==0: load addr_ptr <= bits[2:0].
    - Write command: go to WDATA.
    - Read command: go to RDATA, tx_byte <= reg[bits[2:0]], addr_ptr <= bits[2:0]+1.
  - CMD, rx_valid with bits[6:3]!=0: go to DISCARD, err_count++.
  - WDATA, each rx_valid:
    - addr_ptr 0–5: reg[addr_ptr] <= rx_byte, wr_strobe=1, wr_addr=addr_ptr.
    - addr_ptr 6 or 7: write dropped, err_count++, no wr_strobe.
    - In both cases addr_ptr++. tx_byte stays 8'h00.
  - RDATA, each rx_valid: tx_byte <= reg[addr_ptr], addr_ptr++.
  - DISCARD: rx_valid ignored, tx_byte stays 8'h00.
  - Any non-IDLE state, sel_active low: go to IDLE and pulse frame_done. addr_ptr and tx_byte are held.
- addr_ptr is 3 bits and wraps 7 -> 0.
- err_count saturates at 8'hFF and is never cleared except by reset.
- Simultaneous rx_valid and sel_active low: the deassertion wins. The byte is discarded, with no write, no err_count change, and no tx update.
- Write to reg0: gpio_out updates on the same edge that registers the write.
- Read of register 7 returns err_count as it was before that edge's increment.

## Timing
- Reset values:
  - State IDLE.
  - All registers, tx_byte, gpio_out, err_count: zero.
  - wr_strobe, frame_done: 0.
  - wr_addr: 0.
  - sel_active history: 0.
- A reset asserted mid-frame aborts the frame immediately.
  - No frame_done is produced.
  - If sel_active is still high after reset release, the block stays in IDLE until sel_active goes low and then high again.
- tx_byte latency: valid on the edge after rx_valid, i.e. 1 cycle. The slave samples tx_byte at least 2 ico_clk cycles later, when it starts shifting the next byte.
- wr_strobe, wr_addr, err_count, frame_done: all registered, asserted for exactly 1 cycle after the triggering rx_valid or sel_active edge.
- Frame start needs sel_active low for at least 1 cycle, then high.

## Test plan
- Write burst: frame bytes 8'h80, 8'h05, 8'hA3.
  - reg0=8'h05, reg1=8'hA3.
  - gpio_out=4'h5 one cycle after the second rx_valid.
  - Two wr_strobe pulses with wr_addr 0 then 1.
  - One frame_done.
- Read burst with wrap: preload reg5=8'h55, then frame bytes 8'h05, 8'h00, 8'h00, 8'h00.
  - tx_byte sequence after each rx_valid: 8'h55, ID_VALUE 8'h1C, err_count, reg0.
- Errors: frame 8'h48 then 8'hFF; then frame 8'h86, 8'h11.
  - err_count=2.
  - reg6 still reads 8'h1C.
  - No wr_strobe.
- Saturation: 300 invalid command frames.
  - err_count stops at 8'hFF.
  - A read of address 7 returns 8'hFF.
- Abort: sel_active falls in the same cycle as rx_valid of a data byte 8'h77 in a write frame.
  - No write, no wr_strobe.
  - frame_done pulses; state IDLE.
- Reset mid-frame: assert ico_rst_n low during WDATA with sel_active held high, then release.
  - All outputs zero.
  - Further rx_valid pulses are ignored until sel_active toggles low then high.
